// File: rtl/elevator_pkg.sv
// Shared types and constants for the three-floor elevator controller.
// Debug ports are enabled with the ELEVATOR_STATE_DBG_EN macro in the top module.
package elevator_pkg;

  localparam int NUM_FLOORS = 3;

  // Enum order is the debug encoding: CLOSING_DOORS1 = 0 ... DOWN_2TO1 = 9.
  typedef enum logic [3:0] {
    CLOSING_DOORS1 = 4'd0,
    CLOSING_DOORS2 = 4'd1,
    CLOSING_DOORS3 = 4'd2,
    OPENED_DOORS1  = 4'd3,
    OPENED_DOORS2  = 4'd4,
    OPENED_DOORS3  = 4'd5,
    UP_1TO2        = 4'd6,
    UP_2TO3        = 4'd7,
    DOWN_3TO2      = 4'd8,
    DOWN_2TO1      = 4'd9
  } elev_state_t;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  localparam logic [1:0] FS_MID = 2'b00;
  localparam logic [1:0] FS_F1  = 2'b01;
  localparam logic [1:0] FS_F2  = 2'b10;
  localparam logic [1:0] FS_F3  = 2'b11;

endpackage

// File: rtl/elevator_req_reg.sv
// Per-floor request latch; ereq merges live button presses so the FSM can
// react in the same cycle a button goes high.
module elevator_req_reg
  import elevator_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS:1]   set,
  input  logic [NUM_FLOORS:1]   clear,
  output logic [NUM_FLOORS:1]   req,
  output logic [NUM_FLOORS:1]   ereq
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req <= '0;
    end else begin
      // Clear is applied after set so a held button cannot survive the door opening.
      req <= (req | set) & ~clear;
    end
  end

  assign ereq = req | set;

endmodule

// File: rtl/elevator_controller.sv
// Three-floor elevator car controller: request latching, door/travel sequencing, Moore outputs.
// Define ELEVATOR_STATE_DBG_EN to expose state_dbg and req_dbg.
module elevator_controller
  import elevator_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       UP1,
  input  logic       UP2,
  input  logic       DOWN2,
  input  logic       DOWN3,
  input  logic       FLOOR1,
  input  logic       FLOOR2,
  input  logic       FLOOR3,
  input  logic       DC,
  input  logic [1:0] FS,
  output logic       door,
  output logic [1:0] direction
`ifdef ELEVATOR_STATE_DBG_EN
  ,
  output logic [3:0] state_dbg,
  output logic [2:0] req_dbg
`endif
);

  elev_state_t             state, state_next;
  logic                    last_up;
  logic [NUM_FLOORS:1]     set, clear, req, ereq;

  assign set = {DOWN3 | FLOOR3, UP2 | DOWN2 | FLOOR2, UP1 | FLOOR1};

  elevator_req_reg u_req_reg (
    .clk   (clk),
    .rst   (rst),
    .set   (set),
    .clear (clear),
    .req   (req),
    .ereq  (ereq)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLOSING_DOORS1;
      last_up <= 1'b1;
    end else begin
      state <= state_next;
      if (state_next == UP_1TO2 || state_next == UP_2TO3) begin
        last_up <= 1'b1;
      end else if (state_next == DOWN_3TO2 || state_next == DOWN_2TO1) begin
        last_up <= 1'b0;
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    door       = 1'b1;
    direction  = DIR_STOP;
    clear      = '0;

    unique case (state)
      CLOSING_DOORS1: begin
        if (ereq[1])                     state_next = OPENED_DOORS1;
        else if (DC && (ereq[2] || ereq[3])) state_next = UP_1TO2;
      end
      CLOSING_DOORS2: begin
        if (ereq[2]) begin
          state_next = OPENED_DOORS2;
        end else if (DC) begin
          // Requests on both sides: keep going the way the car last travelled.
          if (ereq[3] && ereq[1]) state_next = last_up ? UP_2TO3 : DOWN_2TO1;
          else if (ereq[3])       state_next = UP_2TO3;
          else if (ereq[1])       state_next = DOWN_2TO1;
        end
      end
      CLOSING_DOORS3: begin
        if (ereq[3])                     state_next = OPENED_DOORS3;
        else if (DC && (ereq[1] || ereq[2])) state_next = DOWN_3TO2;
      end
      OPENED_DOORS1: begin
        door     = 1'b0;
        clear[1] = 1'b1;
        if (ereq[2] || ereq[3]) state_next = CLOSING_DOORS1;
      end
      OPENED_DOORS2: begin
        door     = 1'b0;
        clear[2] = 1'b1;
        if (ereq[1] || ereq[3]) state_next = CLOSING_DOORS2;
      end
      OPENED_DOORS3: begin
        door     = 1'b0;
        clear[3] = 1'b1;
        if (ereq[1] || ereq[2]) state_next = CLOSING_DOORS3;
      end
      UP_1TO2: begin
        direction = DIR_UP;
        if (FS == FS_F2) state_next = (ereq[2] || !ereq[3]) ? OPENED_DOORS2 : UP_2TO3;
      end
      UP_2TO3: begin
        direction = DIR_UP;
        if (FS == FS_F3) state_next = OPENED_DOORS3;
      end
      DOWN_3TO2: begin
        direction = DIR_DOWN;
        if (FS == FS_F2) state_next = (ereq[2] || !ereq[1]) ? OPENED_DOORS2 : DOWN_2TO1;
      end
      DOWN_2TO1: begin
        direction = DIR_DOWN;
        if (FS == FS_F1) state_next = OPENED_DOORS1;
      end
      default: state_next = CLOSING_DOORS1;
    endcase
  end

`ifdef ELEVATOR_STATE_DBG_EN
  assign state_dbg = state;
  assign req_dbg   = req;
`else
  logic unused_req;
  assign unused_req = ^req;
`endif

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller with a floor/phase-level reference model
// compared against door and direction on every falling clock edge.
module tb_elevator_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       UP1 = 1'b0, UP2 = 1'b0, DOWN2 = 1'b0, DOWN3 = 1'b0;
  logic       FLOOR1 = 1'b0, FLOOR2 = 1'b0, FLOOR3 = 1'b0;
  logic       DC = 1'b0;
  logic [1:0] FS = 2'b01;
  logic       door;
  logic [1:0] direction;

  int n_vec = 0;
  int n_err = 0;

  elevator_controller dut (
    .clk       (clk),
    .rst       (rst),
    .UP1       (UP1),
    .UP2       (UP2),
    .DOWN2     (DOWN2),
    .DOWN3     (DOWN3),
    .FLOOR1    (FLOOR1),
    .FLOOR2    (FLOOR2),
    .FLOOR3    (FLOOR3),
    .DC        (DC),
    .FS        (FS),
    .door      (door),
    .direction (direction)
  );

  always #5 clk = ~clk;

  // Reference model: the car is closing, open, or moving from floor fl in direction dir.
  localparam int PH_CLOSE = 0;
  localparam int PH_OPEN  = 1;
  localparam int PH_MOVE  = 2;

  typedef struct {
    int       ph;
    int       fl;
    int       dir;
    int       last;
    bit [3:1] rq;
  } model_t;

  model_t mdl;

  function automatic int fs_floor(logic [1:0] fs);
    case (fs)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 3;
      default: return 0;
    endcase
  endfunction

  function automatic model_t step(model_t m);
    model_t   n;
    bit [3:1] btn, e;
    bit       above, below;
    int       nxt;
    n     = m;
    btn   = {DOWN3 | FLOOR3, UP2 | DOWN2 | FLOOR2, UP1 | FLOOR1};
    e     = m.rq | btn;
    above = 1'b0;
    below = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (e[k] && k > m.fl) above = 1'b1;
      if (e[k] && k < m.fl) below = 1'b1;
    end
    n.rq = m.rq | btn;
    if (m.ph == PH_OPEN) n.rq[m.fl] = 1'b0;
    case (m.ph)
      PH_CLOSE: begin
        if (e[m.fl]) begin
          n.ph = PH_OPEN;
        end else if (DC && (above || below)) begin
          if (above && below) n.dir = m.last;
          else                n.dir = above ? 1 : -1;
          n.ph   = PH_MOVE;
          n.last = n.dir;
        end
      end
      PH_OPEN: if (above || below) n.ph = PH_CLOSE;
      default: begin
        nxt = m.fl + m.dir;
        if (fs_floor(FS) == nxt) begin
          n.fl = nxt;
          // Pass floor 2 only if it is not wanted and something lies further on.
          if (!(nxt == 2 && !e[2] && (m.dir > 0 ? e[3] : e[1]))) n.ph = PH_OPEN;
        end
      end
    endcase
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl <= '{ph: PH_CLOSE, fl: 1, dir: 1, last: 1, rq: 3'b000};
    end else begin
      mdl <= step(mdl);
    end
  end

  logic       m_door;
  logic [1:0] m_direction;
  always_comb begin
    m_door      = (mdl.ph != PH_OPEN);
    m_direction = 2'b00;
    if (mdl.ph == PH_MOVE) m_direction = (mdl.dir > 0) ? 2'b01 : 2'b10;
  end

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    check("door_vs_model", {1'b0, door}, {1'b0, m_door});
    check("direction_vs_model", direction, m_direction);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic d, input logic [1:0] dir);
    check({name, "_door"}, {1'b0, door}, {1'b0, d});
    check({name, "_dir"}, direction, dir);
  endtask

  initial begin
    cyc(3);
    rst = 1'b1;
    cyc(1);
    expect_out("reset", 1'b1, 2'b00);

    UP1 = 1'b1; cyc(3); UP1 = 1'b0;
    expect_out("open1", 1'b0, 2'b00);

    FLOOR2 = 1'b1; cyc(3); FLOOR2 = 1'b0;
    expect_out("closing1", 1'b1, 2'b00);
    DC = 1'b1; cyc(1);
    expect_out("up1to2", 1'b1, 2'b01);
    FS = 2'b00; cyc(2);
    expect_out("travel_hold", 1'b1, 2'b01);
    FS = 2'b10; cyc(1);
    expect_out("arrive2", 1'b0, 2'b00);
    cyc(2);
    expect_out("open2_dc_ignored", 1'b0, 2'b00);

    // Requests above and below at floor 2 with last direction up.
    FLOOR1 = 1'b1; FLOOR3 = 1'b1; cyc(1); FLOOR1 = 1'b0; FLOOR3 = 1'b0;
    expect_out("closing2", 1'b1, 2'b00);
    cyc(1);
    expect_out("tie_goes_up", 1'b1, 2'b01);
    FS = 2'b00; cyc(1);
    FS = 2'b11; cyc(1);
    expect_out("arrive3", 1'b0, 2'b00);
    cyc(1);
    expect_out("closing3", 1'b1, 2'b00);
    cyc(1);
    expect_out("down3to2", 1'b1, 2'b10);
    FS = 2'b00; cyc(1);
    FS = 2'b10; cyc(1);
    expect_out("pass2_down", 1'b1, 2'b10);
    FS = 2'b00; cyc(1);
    FS = 2'b01; cyc(1);
    expect_out("arrive1", 1'b0, 2'b00);

    // Express trip 1 -> 3 without stopping at 2.
    FLOOR3 = 1'b1; cyc(1); FLOOR3 = 1'b0;
    cyc(1);
    expect_out("up_from1", 1'b1, 2'b01);
    FS = 2'b00; cyc(1);
    FS = 2'b10; cyc(1);
    expect_out("pass2_up", 1'b1, 2'b01);
    FS = 2'b00; cyc(1);
    FS = 2'b11; cyc(1);
    expect_out("express3", 1'b0, 2'b00);

    // Same-floor press while closing reopens even with DC=1.
    FLOOR2 = 1'b1; cyc(1); FLOOR2 = 1'b0;
    FLOOR3 = 1'b1; cyc(1); FLOOR3 = 1'b0;
    expect_out("reopen3", 1'b0, 2'b00);
    cyc(2);
    expect_out("down_to2", 1'b1, 2'b10);
    FS = 2'b00; cyc(1);
    FS = 2'b10; cyc(1);
    expect_out("stop2_down", 1'b0, 2'b00);

    // Reset in the middle of Up1To2.
    FLOOR1 = 1'b1; cyc(1); FLOOR1 = 1'b0;
    cyc(1);
    FS = 2'b00; cyc(1);
    FS = 2'b01; cyc(1);
    FLOOR2 = 1'b1; cyc(1); FLOOR2 = 1'b0;
    cyc(1);
    expect_out("pre_reset_up", 1'b1, 2'b01);
    FS = 2'b00; cyc(1);
    #2 rst = 1'b0;
    #1 expect_out("async_reset", 1'b1, 2'b00);
    cyc(2);
    rst = 1'b1;
    cyc(3);
    expect_out("req_cleared", 1'b1, 2'b00);

    cyc(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/elevator_controller.md
Name: elevator_controller

Overview:
- Three-floor elevator controller FSM that registers hall and cabin calls.
- Sequences the car door through close → travel → open.
- Drives `door` and `direction` to the car's door and motor actuators.
- Sits between the push-button/sensor inputs and the actuators; one instance per car.

Parameters:
- None. Floor count is fixed at 3.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- UP1  in  1  hall up-call, floor 1.
- UP2  in  1  hall up-call, floor 2.
- DOWN2  in  1  hall down-call, floor 2.
- DOWN3  in  1  hall down-call, floor 3.
- FLOOR1  in  1  cabin button, floor 1.
- FLOOR2  in  1  cabin button, floor 2.
- FLOOR3  in  1  cabin button, floor 3.
- DC  in  1  doors-closed sensor (1 = fully closed).
- FS  in  2  floor sensor: 01 = floor 1, 10 = floor 2, 11 = floor 3, 00 = between floors.
- door  out  1  door command: 1 = close/hold closed, 0 = open.
- direction  out  2  motor command: 00 = stop, 01 = up, 10 = down, 11 = unused (never driven).

Behaviour:
- Request register `req[3:1]`:
  - Set: floor 1 by UP1|FLOOR1; floor 2 by UP2|DOWN2|FLOOR2; floor 3 by DOWN3|FLOOR3.
  - Effective request `ereq` = `req` OR live button inputs, so a press affects the next-state decision in the same cycle (1-cycle response).
  - Cleared when the FSM is in OpenedDoors_n for floor n. Clear wins over a simultaneous set for that floor.
- States: ClosingDoors1/2/3, OpenedDoors1/2/3, Up1To2, Up2To3, Down3To2, Down2To1.
- Outputs are Moore:
  - ClosingDoors_n: door=1, direction=00.
  - OpenedDoors_n: door=0, direction=00.
  - Up*: door=1, direction=01.
  - Down*: door=1, direction=10.
- Reset (rst=0, asynchronous): state=ClosingDoors1, `req`=000, door=1, direction=00, last_dir=up. Reset mid-travel also returns to ClosingDoors1 regardless of FS.
- Transitions out of ClosingDoors_n, in priority order:
  1. ereq[n] → OpenedDoors_n (door reopens; DC ignored).
  2. Else if DC=1 and a request exists both above and below: go in last_dir.
  3. Else if DC=1 and ereq above n → Up from n.
  4. Else if DC=1 and ereq below n → Down from n.
  5. Otherwise hold.
- OpenedDoors_n:
  - Any ereq for another floor → ClosingDoors_n.
  - Else hold.
  - DC is ignored in this state.
- Up1To2 / Down3To2:
  - Only reacts when FS=10, otherwise hold.
  - With FS=10: stop to OpenedDoors2 if ereq[2], or if no request remains further in the travel direction.
  - Otherwise continue to Up2To3 / Down2To1.
- Up2To3: FS=11 → OpenedDoors3. Down2To1: FS=01 → OpenedDoors1. Other FS values hold.
- last_dir updates on entry to any Up*/Down* state.
- Buttons held for many cycles are harmless; a request is simply re-set after the car leaves that floor.

Optional Feature:
- Macro: ELEVATOR_STATE_DBG_EN.
- Defined: adds output `state_dbg [3:0]` carrying the encoded current state.
  - Encoding in enum order: ClosingDoors1=0 … Down2To1=9.
  - Also adds output `req_dbg [2:0]` carrying `req`.
- Undefined: neither port exists; core behaviour is identical.

Decomposition:
- Package `elevator_pkg` holds:
  - state enum `elev_state_t`;
  - direction constants DIR_STOP/DIR_UP/DIR_DOWN;
  - floor-sensor constants FS_MID/FS_F1/FS_F2/FS_F3.
- One sub-module, `elevator_req_reg`: the 3-bit request register with set/clear logic and the `ereq` output.
- FSM and output decode stay in elevator_controller.

Test Plan:
- Release reset, wait 1 cycle → ClosingDoors1, door=1, direction=00.
- UP1=1 for 3 cycles in ClosingDoors1 → OpenedDoors1, door=0, direction=00.
- In OpenedDoors1 press FLOOR2 for 3 cycles → ClosingDoors1, door=1; then DC=1 for 1 cycle → Up1To2, direction=01; then FS=10 → OpenedDoors2, door=0, direction=00; DC still 1 → stays OpenedDoors2.
- In OpenedDoors1 press FLOOR3, DC=1, FS=10 → Up2To3 without stopping at floor 2; FS=11 → OpenedDoors3.
- At floor 2 with last_dir=up, press FLOOR1 and FLOOR3 together, DC=1 → Up2To3.
- Assert rst=0 during Up1To2 → immediately ClosingDoors1, direction=00, req=000.
